serial_logic_unit: RTL and testbench

Bit-serial counterpart of the team's 16-bit parallel bitwise logic ops (OR/AND/XOR/NOR) on FP16 bit patterns. Accepts two 16-bit operands and an opcode through a valid/ready handshake and processes BITS_PER_CYCLE bits per clock, LSB first. Returns the 16-bit result through a second valid/ready handshake. Sits in the FloatingPointOperations area as the area-reduced alternative where the parallel logic ops are too wide.

---
 rtl/fp_logic_pkg.sv | 19 +
 rtl/serial_logic_unit_if.sv | 46 ++++
 rtl/logic_bit_slice.sv | 27 ++
 rtl/serial_logic_unit.sv | 125 ++++++++++++
 tb/tb_serial_logic_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_logic_pkg.sv
// Shared definitions for the serial bitwise logic unit: opcodes, FSM encoding, default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_logic_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Operand request / result handshake bundle for serial_logic_unit.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, op, a, b (request); out_valid, out_ready, out (result); busy (status).
// slave = the unit, master = the requester/consumer.
interface serial_logic_unit_if
    import fp_logic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output busy
    );

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  busy
    );

endinterface

// File: rtl/logic_bit_slice.sv
// Applies OR/AND/XOR/NOR to one BITS_PER_CYCLE-wide slice of the operands.
// Latency: combinational.
// Backpressure: none.
// Ports: op (opcode), a_slice/b_slice (operand slices), r_slice (result slice).
module logic_bit_slice
    import fp_logic_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [1:0]                op,
    input  logic [BITS_PER_CYCLE-1:0] a_slice,
    input  logic [BITS_PER_CYCLE-1:0] b_slice,
    output logic [BITS_PER_CYCLE-1:0] r_slice
);

    always_comb begin
        r_slice = '0;
        case (op)
            OP_OR:   r_slice = a_slice | b_slice;
            OP_AND:  r_slice = a_slice & b_slice;
            OP_XOR:  r_slice = a_slice ^ b_slice;
            OP_NOR:  r_slice = ~(a_slice | b_slice);
            default: r_slice = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise OR/AND/XOR/NOR on WIDTH-bit raw patterns, BITS_PER_CYCLE bits per clock, LSB first.
// Latency: out_valid rises WIDTH/BITS_PER_CYCLE edges after the accepting edge; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, indefinitely.
// Ports: clk, rst_n (sync, active-low); bus = serial_logic_unit_if.slave (request, result, busy).
module serial_logic_unit
    import fp_logic_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEFAULT,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_logic_unit_if.slave bus
);

    localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > WIDTH) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_bpc
            $error("serial_logic_unit: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    state_t                    state;
    state_t                    state_nxt;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res_sh;
    logic [WIDTH-1:0]          res_nxt;
    logic [WIDTH-1:0]          out_q;
    logic [1:0]                op_q;
    logic [CNT_W-1:0]          cnt;
    logic                      last_slice;
    logic [BITS_PER_CYCLE-1:0] r_slice;

    assign last_slice = (cnt == CNT_W'(NSLICE - 1));

    logic_bit_slice #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_slice (
        .op      (op_q),
        .a_slice (a_sh[BITS_PER_CYCLE-1:0]),
        .b_slice (b_sh[BITS_PER_CYCLE-1:0]),
        .r_slice (r_slice)
    );

    // New slice enters at the MSB end so that after NSLICE steps slice 0
    // has walked down to bit 0. Written as shifts so BITS_PER_CYCLE == WIDTH works.
    assign res_nxt = (res_sh >> BITS_PER_CYCLE) | (WIDTH'(r_slice) << (WIDTH - BITS_PER_CYCLE));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_slice)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; in_ready is gated by rst_n so it reads 0 during the reset cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: bus.in_ready = rst_n;
            RUN:  bus.busy     = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.out = out_q;

    // Datapath: operand shifters, result shifter, counter, held output.
    // out_q is a separate register so out stays put while the next op shifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            out_q  <= '0;
            op_q   <= OP_OR;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        op_q   <= bus.op;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> BITS_PER_CYCLE;
                    b_sh   <= b_sh >> BITS_PER_CYCLE;
                    res_sh <= res_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_slice) begin
                        out_q <= res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
module tb_serial_logic_unit;
    import fp_logic_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_logic_unit_if #(.WIDTH(16)) if0 ();
    serial_logic_unit_if #(.WIDTH(16)) if1 ();

    serial_logic_unit #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    serial_logic_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_res    = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
        case (o)
            2'b00:   return x | y;
            2'b01:   return x & y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Present one request, wait (bounded) for acceptance, queue its expected result.
    // Returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] ov,
                        input logic [15:0] ev, output bit ok);
        int t = 0;
        if0.a = av;
        if0.b = bv;
        if0.op = ov;
        if0.in_valid = 1'b1;
        while (!if0.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 200);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", if0.in_ready);
            if0.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(ev);
        n_acc++;
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!if0.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!if0.out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_valid_timeout: out_valid=0 required 1");
        end
    endtask

    task automatic run4(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [1:0] ov, input logic [15:0] ev);
        int lat = 0;
        @(negedge clk);
        if1.a = av;
        if1.b = bv;
        if1.op = ov;
        if1.in_valid = 1'b1;
        check({name, "_ready"}, if1.in_ready, 1);
        @(negedge clk);
        if1.in_valid = 1'b0;
        while (!if1.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, lat, 4);
        check({name, "_out"}, if1.out, ev);
    endtask

    // Scoreboard monitor: pops on every result transfer.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && if0.out_valid && if0.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got %0h required none", if0.out);
                end else begin
                    check("scoreboard", if0.out, exp_q.pop_front());
                end
                n_res++;
            end
        end
    end

    logic [1:0]  ops2 [4] = '{OP_OR, OP_AND, OP_XOR, OP_NOR};
    logic [15:0] exps2[4] = '{16'hFFF0, 16'hF000, 16'h0FF0, 16'h000F};

    initial begin
        int lat;
        int base;
        bit ok;
        bit seen;

        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.op = OP_OR; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.op = OP_OR; if1.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", if0.in_ready, 0);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_out", if0.out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", if0.in_ready, 1);

        // Single OR with latency
        send(16'h3C00, 16'h0055, OP_OR, 16'h3C55, ok);
        wait_out(lat);
        check("lat_or", lat, 16);
        check("busy_done", if0.busy, 1);
        @(negedge clk);
        check("in_ready_return", if0.in_ready, 1);

        // All opcodes on one operand pair
        for (int i = 0; i < 4; i++) begin
            send(16'hF0F0, 16'hFF00, ops2[i], exps2[i], ok);
            wait_out(lat);
            check("lat_ops", lat, 16);
        end

        // Backpressure: result held, inputs ignored
        @(negedge clk);
        if0.out_ready = 1'b0;
        send(16'h1234, 16'h00FF, OP_XOR, 16'h12CB, ok);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if0.in_valid = ~if0.in_valid;
            if0.a = 16'($urandom);
            if0.b = 16'($urandom);
            #1;
            check("bp_out", if0.out, 16'h12CB);
            check("bp_out_valid", if0.out_valid, 1);
            check("bp_in_ready", if0.in_ready, 0);
        end
        @(negedge clk);
        base = n_res;
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_released", if0.out_valid, 0);
        check("bp_out_kept", if0.out, 16'h12CB);
        repeat (5) @(negedge clk);
        #1;
        check("bp_one_transfer", n_res, base + 1);

        // Reset in the middle of RUN
        @(negedge clk);
        send(16'hAAAA, 16'h5555, OP_AND, 16'h0000, ok);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", if0.in_ready, 0);
        @(negedge clk);
        #1;
        check("midrst_out_valid", if0.out_valid, 0);
        check("midrst_busy", if0.busy, 0);
        check("midrst_out", if0.out, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        n_acc--;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_rel", if0.in_ready, 1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (if0.out_valid) seen = 1'b1;
        end
        check("midrst_no_out", seen, 0);
        send(16'hFFFF, 16'h0000, OP_OR, 16'hFFFF, ok);
        wait_out(lat);
        check("lat_after_rst", lat, 16);
        @(negedge clk);

        // Random regression with random gaps and out_ready stalls
        base = n_res;
        fork
            begin
                logic [15:0] ra, rb;
                logic [1:0]  ro;
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(negedge clk);
                        if0.a = 16'($urandom);
                        if0.b = 16'($urandom);
                    end
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    ro = 2'($urandom_range(0, 3));
                    send(ra, rb, ro, ref_op(ra, rb, ro), ok);
                    if (!ok) break;
                end
            end
            begin
                int t = 0;
                while (n_res < base + 1000 && t < 40000) begin
                    @(negedge clk);
                    if0.out_ready = 1'($urandom_range(0, 1));
                    t++;
                end
                if0.out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        #1;
        check("result_count", n_res, n_acc);
        check("queue_empty", exp_q.size(), 0);

        // BITS_PER_CYCLE = 4 instance
        run4("bpc4_xor", 16'h1234, 16'h8421, OP_XOR, 16'h9615);
        run4("bpc4_and", 16'h1234, 16'h8421, OP_AND, 16'h0020);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
